play_session: RTL
=================

# play_session

Parametrised successor to the single-song play-mode controller. Owns one play session: it accepts target notes from the song sequencer, judges player hits against them with difficulty-scaled timing windows, and keeps base score, bonus score and combo. At song end it commits the result to a per-user best-record table. It sits between the song sequencer / key-hit capture and the scoreboard display.

## Interface
Parameters:
- USERS, 4, number of user slots in the best-record table (≥2)
- SCORE_W, 20, score accumulator width
- COMBO_W, 12, combo counter width
- TIME_W, 16, timestamp width (free-running system clock count)
- NOTE_W, 3, note code width

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- en  in  1  session active; low forces IDLE and clears session state
- user  in  $clog2(USERS)  user slot; sampled on IDLE→ARM
- difficulty  in  2  window select; sampled on IDLE→ARM
- now  in  TIME_W  current timestamp
- goal_valid / goal_ready  in / out  1 / 1  target-note handshake
- goal_note, goal_time  in  NOTE_W, TIME_W  target note and due time
- hit_valid  in  1  single-cycle player hit strobe
- hit_note, hit_time  in  NOTE_W, TIME_W  hit note and press time
- song_end  in  1  single-cycle strobe: no more goals
- base_score, bonus_score  out  SCORE_W  session totals
- combo, max_combo  out  COMBO_W  current and peak combo
- judge_valid  out  1  one-cycle strobe per judged note
- judge_level  out  2  3=PERFECT, 2=GREAT, 1=GOOD, 0=MISS
- done  out  1  high in DONE
- best_score  out  SCORE_W  table best total for the latched user
- best_combo  out  COMBO_W  table best combo for the latched user

## Operation
- States: IDLE, ARM, WAIT_HIT, JUDGE, COMMIT, DONE.
- IDLE: en=1 → ARM. Latch user and difficulty. Clear scores, combos and the pending-end flag.
- ARM: goal_ready=1. goal_valid → capture goal, go to WAIT_HIT. song_end (with or without goal_valid) → COMMIT, and the goal is not accepted. hit_valid is ignored.
- WAIT_HIT: P = 8 >> difficulty. dt = hit_time − goal_time, signed, TIME_W+1 bits.
  - Hit with dt < −4P is ignored; stay in this state.
  - Any other hit → JUDGE.
  - (now − goal_time) mod 2^TIME_W in [4P+1, 2^(TIME_W−1)) with no hit that cycle → JUDGE as MISS.
  - Hit and timeout in the same cycle: the hit wins.
  - song_end here sets the pending-end flag.
- JUDGE (1 cycle): grade.
  - Note mismatch or |dt| > 4P → MISS.
  - Otherwise |dt| ≤ P → PERFECT, ≤ 2P → GREAT, else GOOD.
  - Non-MISS: combo+1 (saturating), base += level, bonus += (combo+1) >> 3, max_combo = max(max_combo, combo+1).
  - MISS: combo = 0.
  - All adds saturate at all-ones.
  - Next state is COMMIT if the pending-end flag is set or song_end is asserted, else ARM.
- COMMIT (1 cycle): for the latched user, best_score = max(best_score, base+bonus), with the sum saturating; best_combo = max(best_combo, max_combo). The two maxima are updated independently. Next state DONE.
- DONE: hold all outputs until en=0.
- en=0 in any state → IDLE next cycle, with no commit. The record table is preserved.

## Timing
- Reset: state IDLE; goal_ready, judge_valid and done = 0; all scores and combos = 0; every table entry = 0.
- Handshake: a goal transfers on the cycle where goal_valid & goal_ready. goal_ready falls the next cycle.
- Latency: hit accepted at cycle t → judge_valid, judge_level and updated scores visible at t+1 → goal_ready high at t+2.
- Back-to-back: at most one note per 3 cycles (ARM, WAIT_HIT, JUDGE).
- best_score and best_combo are combinational reads of the latched user's entry. They show the new values the cycle after COMMIT, i.e. when done rises.
- Timestamps wrap modulo 2^TIME_W. All comparisons use the modular differences defined above.

## Configuration
- PLAY_HISCORE_EN defined: record table present; COMMIT updates it.
- PLAY_HISCORE_EN undefined: no table storage; COMMIT is still a 1-cycle state with no write; best_score and best_combo are tied to 0.

## Test plan
- difficulty=0 (P=8); goal (note 2, t=100); hit (note 2, t=104) → judge_level=3, base=3, bonus=0, combo=1.
- Nine consecutive PERFECT hits → on the 8th judge, bonus increments by 1 (combo 8), on the 9th by 1 more; base=27, bonus=2, max_combo=9.
- difficulty=3 (P=1); goal t=200; no hit; now=205 → MISS at the first cycle now−goal_time=5; combo=0, base unchanged.
- Goal at t=0xFFFE; hit_time=0x0001 with matching note, difficulty=0 → dt=+3, PERFECT (wrap-around).
- user=1: session A commits total 30, combo 5; session B commits total 20, combo 7 → best_score=30, best_combo=7. Then rst_n=0 for 1 cycle → both read 0.
- song_end during WAIT_HIT, then hit at dt=0 → PERFECT judged, then COMMIT, then done=1. With PLAY_HISCORE_EN undefined, best outputs stay 0.

Source files
------------

// File: rtl/play_session.sv
`timescale 1ns/1ps
// play_session: one play session of the rhythm game.
// Accepts target notes from the song sequencer, judges player hits against
// them with difficulty-scaled timing windows, and keeps base score, bonus
// score and combo. At song end the result is committed to a per-user
// best-record table.
//
// Optional feature macro: PLAY_HISCORE_EN
//   defined   - per-user best-record table present, COMMIT updates it
//   undefined - no table; best_score / best_combo read as 0
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   en                      session active; low returns to IDLE and clears
//   user, difficulty        user slot / window select, latched on IDLE->ARM
//   now                     free-running timestamp
//   goal_valid/goal_ready   target-note handshake (goal_note, goal_time)
//   hit_valid               player hit strobe (hit_note, hit_time)
//   song_end                strobe: no more goals
//   base_score, bonus_score session totals
//   combo, max_combo        current and peak combo
//   judge_valid/judge_level one-cycle judgement strobe; 3..0 = PERFECT..MISS
//   done                    session result committed
//   best_score, best_combo  best record of the latched user
module play_session #(
    parameter int unsigned USERS   = 4,
    parameter int unsigned SCORE_W = 20,
    parameter int unsigned COMBO_W = 12,
    parameter int unsigned TIME_W  = 16,
    parameter int unsigned NOTE_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [$clog2(USERS)-1:0] user,
    input  logic [1:0]               difficulty,
    input  logic [TIME_W-1:0]        now,
    input  logic                     goal_valid,
    output logic                     goal_ready,
    input  logic [NOTE_W-1:0]        goal_note,
    input  logic [TIME_W-1:0]        goal_time,
    input  logic                     hit_valid,
    input  logic [NOTE_W-1:0]        hit_note,
    input  logic [TIME_W-1:0]        hit_time,
    input  logic                     song_end,
    output logic [SCORE_W-1:0]       base_score,
    output logic [SCORE_W-1:0]       bonus_score,
    output logic [COMBO_W-1:0]       combo,
    output logic [COMBO_W-1:0]       max_combo,
    output logic                     judge_valid,
    output logic [1:0]               judge_level,
    output logic                     done,
    output logic [SCORE_W-1:0]       best_score,
    output logic [COMBO_W-1:0]       best_combo
);

    localparam int unsigned UW = $clog2(USERS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_HIT,
        S_JUDGE,
        S_COMMIT,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [UW-1:0]      user_q;
    logic [1:0]         diff_q;
    logic [NOTE_W-1:0]  goal_note_q;
    logic [TIME_W-1:0]  goal_time_q;
    logic               pend_end;
    logic [SCORE_W-1:0] base_q, bonus_q;
    logic [COMBO_W-1:0] combo_q, max_q;
    logic [1:0]         level_q;

    // Timing windows: P, 2P, 4P with P = 8 >> difficulty
    logic [3:0]        p4;
    logic [TIME_W:0]   win1, win2, win4;
    // Modular hit offset, sign-extended to TIME_W+1 bits
    logic [TIME_W-1:0] dt_mod, el;
    logic [TIME_W:0]   dt_ext, abs_dt;
    logic              hit_early, timeout, hit_take, judge_now;
    logic [1:0]        hit_level, new_level;

    assign p4   = 4'd8 >> diff_q;
    assign win1 = (TIME_W+1)'(p4);
    assign win2 = win1 << 1;
    assign win4 = win1 << 2;

    assign dt_mod    = hit_time - goal_time_q;
    assign dt_ext    = {dt_mod[TIME_W-1], dt_mod};
    assign abs_dt    = dt_ext[TIME_W] ? ('0 - dt_ext) : dt_ext;
    assign hit_early = dt_ext[TIME_W] && (abs_dt > win4);

    // Elapsed time counts as late only in the first half of the wrap range,
    // so a goal whose due time is still ahead never times out.
    assign el        = now - goal_time_q;
    assign timeout   = !el[TIME_W-1] && ({1'b0, el} > win4);

    assign hit_take  = hit_valid && !hit_early;
    assign judge_now = (state == S_WAIT_HIT) && (hit_take || timeout);
    assign new_level = hit_take ? hit_level : 2'd0;

    always_comb begin
        hit_level = 2'd0;
        if ((hit_note == goal_note_q) && (abs_dt <= win4)) begin
            if (abs_dt <= win1)      hit_level = 2'd3;
            else if (abs_dt <= win2) hit_level = 2'd2;
            else                     hit_level = 2'd1;
        end
    end

    // Saturating score arithmetic
    logic [COMBO_W-1:0] combo_inc;
    logic [SCORE_W:0]   base_sum, bonus_sum;
    logic [SCORE_W-1:0] base_nx, bonus_nx;

    assign combo_inc = (&combo_q) ? combo_q : combo_q + COMBO_W'(1);
    assign base_sum  = {1'b0, base_q} + (SCORE_W+1)'(new_level);
    assign bonus_sum = {1'b0, bonus_q} + (SCORE_W+1)'(combo_inc >> 3);
    assign base_nx   = base_sum[SCORE_W]  ? '1 : base_sum[SCORE_W-1:0];
    assign bonus_nx  = bonus_sum[SCORE_W] ? '1 : bonus_sum[SCORE_W-1:0];

`ifdef PLAY_HISCORE_EN
    logic [SCORE_W-1:0] tbl_score [USERS];
    logic [COMBO_W-1:0] tbl_combo [USERS];
    logic [SCORE_W:0]   total_sum;
    logic [SCORE_W-1:0] total;

    assign total_sum  = {1'b0, base_q} + {1'b0, bonus_q};
    assign total      = total_sum[SCORE_W] ? '1 : total_sum[SCORE_W-1:0];
    assign best_score = tbl_score[user_q];
    assign best_combo = tbl_combo[user_q];
`else
    logic unused_user;
    assign unused_user = ^user_q;
    assign best_score  = '0;
    assign best_combo  = '0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_nx    = state;
        goal_ready  = 1'b0;
        judge_valid = 1'b0;
        done        = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (en) state_nx = S_ARM;
            end
            S_ARM: begin
                goal_ready = 1'b1;
                if (song_end)        state_nx = S_COMMIT;
                else if (goal_valid) state_nx = S_WAIT_HIT;
            end
            S_WAIT_HIT: begin
                if (hit_take || timeout) state_nx = S_JUDGE;
            end
            S_JUDGE: begin
                // Scores were updated on entry, so this cycle only presents them
                judge_valid = 1'b1;
                state_nx    = (pend_end || song_end) ? S_COMMIT : S_ARM;
            end
            S_COMMIT: begin
                state_nx = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
        if (!en) state_nx = S_IDLE;
    end

    // Session datapath and record table
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            user_q      <= '0;
            diff_q      <= '0;
            goal_note_q <= '0;
            goal_time_q <= '0;
            pend_end    <= 1'b0;
            base_q      <= '0;
            bonus_q     <= '0;
            combo_q     <= '0;
            max_q       <= '0;
            level_q     <= '0;
`ifdef PLAY_HISCORE_EN
            for (int unsigned i = 0; i < USERS; i++) begin
                tbl_score[i] <= '0;
                tbl_combo[i] <= '0;
            end
`endif
        end else if (!en) begin
            pend_end <= 1'b0;
            base_q   <= '0;
            bonus_q  <= '0;
            combo_q  <= '0;
            max_q    <= '0;
            level_q  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    user_q   <= user;
                    diff_q   <= difficulty;
                    pend_end <= 1'b0;
                    base_q   <= '0;
                    bonus_q  <= '0;
                    combo_q  <= '0;
                    max_q    <= '0;
                    level_q  <= '0;
                end
                S_ARM: begin
                    if (goal_valid && !song_end) begin
                        goal_note_q <= goal_note;
                        goal_time_q <= goal_time;
                    end
                end
                S_WAIT_HIT: begin
                    if (song_end) pend_end <= 1'b1;
                    if (judge_now) begin
                        level_q <= new_level;
                        if (new_level != 2'd0) begin
                            combo_q <= combo_inc;
                            base_q  <= base_nx;
                            bonus_q <= bonus_nx;
                            if (combo_inc > max_q) max_q <= combo_inc;
                        end else begin
                            combo_q <= '0;
                        end
                    end
                end
                S_COMMIT: begin
`ifdef PLAY_HISCORE_EN
                    if (total > tbl_score[user_q]) tbl_score[user_q] <= total;
                    if (max_q > tbl_combo[user_q]) tbl_combo[user_q] <= max_q;
`endif
                end
                default: ;
            endcase
        end
    end

    assign base_score  = base_q;
    assign bonus_score = bonus_q;
    assign combo       = combo_q;
    assign max_combo   = max_q;
    assign judge_level = level_q;

endmodule
